// File: rtl/reg_update_pkg.sv
// reg_update_pkg: shared definitions for the register update unit.
//   - op_e      : 3-bit micro-op encoding carried on cmd_op.
//   - IDX_*     : default register index assignments (AC, AR, DR, IR, PC, R, TR).
//   - is_write_op: true for ops that write the target register when no error occurs.
package reg_update_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'b000,
        OP_INC   = 3'b001,
        OP_DEC   = 3'b010,
        OP_LOAD  = 3'b011,
        OP_CLR   = 3'b100,
        OP_ADD   = 3'b101,
        OP_INCSZ = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    localparam int unsigned IDX_AC = 0;
    localparam int unsigned IDX_AR = 1;
    localparam int unsigned IDX_DR = 2;
    localparam int unsigned IDX_IR = 3;
    localparam int unsigned IDX_PC = 4;
    localparam int unsigned IDX_R  = 5;
    localparam int unsigned IDX_TR = 6;

    function automatic logic is_write_op(input logic [OP_W-1:0] op);
        return (op != OP_NOP) && (op != OP_RSVD);
    endfunction

endpackage

// File: rtl/reg_update_alu.sv
// reg_update_alu: combinational micro-op evaluator.
// Ports:
//   op      in  3       micro-op (see reg_update_pkg::op_e)
//   operand in  DATA_W  current value of the target register
//   data    in  DATA_W  command operand for LOAD / ADD
//   sel_err in  1       target index is outside the register array
//   result  out DATA_W  value to write (operand unchanged for NOP / error)
//   carry   out 1       carry of INC/INCSZ/ADD, borrow of DEC, else 0
//   err     out 1       reserved opcode or bad index
//   we      out 1       register write enable
module reg_update_alu
    import reg_update_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] operand,
    input  logic [DATA_W-1:0] data,
    input  logic              sel_err,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              err,
    output logic              we
);

    // One extra bit so the MSB captures carry/borrow and the low bits wrap.
    logic [DATA_W:0] sum;

    always_comb begin
        sum = {1'b0, operand};
        unique case (op)
            OP_INC, OP_INCSZ: sum = {1'b0, operand} + (DATA_W+1)'(1);
            OP_DEC:           sum = {1'b0, operand} - (DATA_W+1)'(1);
            OP_LOAD:          sum = {1'b0, data};
            OP_CLR:           sum = '0;
            OP_ADD:           sum = {1'b0, operand} + {1'b0, data};
            default:          sum = {1'b0, operand};
        endcase

        err = sel_err || (op == OP_RSVD);
        we  = !err && is_write_op(op);

        // Errored commands report the untouched operand with no carry.
        if (err) begin
            result = operand;
            carry  = 1'b0;
        end else begin
            result = sum[DATA_W-1:0];
            carry  = sum[DATA_W];
        end
    end

endmodule

// File: rtl/reg_update_unit.sv
// reg_update_unit: register bank plus single-stage update engine.
// A command is latched into S1 on cmd_valid && cmd_ready. S1 reads its target
// register, evaluates the micro-op and, when the done register is free or being
// drained, commits: writes the register, pulses wr_onehot and loads the done
// register. Commit at S1 exit means a following command always sees the update.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_sel, cmd_data     micro-op, target index, operand
//   rd_sel/rd_data                combinational read port (committed value)
//   wr_onehot                     one-hot write strobe, high in the commit cycle
//   done_valid/done_ready         result handshake
//   done_sel/value/zero/carry/err result fields
module reg_update_unit
    import reg_update_pkg::*;
#(
    parameter int unsigned          NUM_REGS  = 8,
    parameter int unsigned          DATA_W    = 16,
    parameter int unsigned          SEL_W     = $clog2(NUM_REGS),
    parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [SEL_W-1:0]    cmd_sel,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [DATA_W-1:0]   rd_data,
    output logic [NUM_REGS-1:0] wr_onehot,
    output logic                done_valid,
    input  logic                done_ready,
    output logic [SEL_W-1:0]    done_sel,
    output logic [DATA_W-1:0]   done_value,
    output logic                done_zero,
    output logic                done_carry,
    output logic                done_err
);

    // Index limit in SEL_W+1 bits so the range check works for any NUM_REGS.
    localparam logic [SEL_W:0] NUM_REGS_X = (SEL_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              s1_valid;
    logic [OP_W-1:0]   s1_op;
    logic [SEL_W-1:0]  s1_sel;
    logic [DATA_W-1:0] s1_data;

    logic              accept;
    logic              advance;
    logic              s1_sel_err;
    logic              rd_sel_err;
    logic [DATA_W-1:0] s1_operand;

    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;
    logic                alu_err;
    logic                alu_we;
    logic [NUM_REGS-1:0] wr_dec;

    // Handshake
    always_comb begin
        advance   = s1_valid && (!done_valid || done_ready);
        cmd_ready = !s1_valid || advance;
        accept    = cmd_valid && cmd_ready;
    end

    // Operand fetch and read port; out-of-range indices read as zero.
    always_comb begin
        s1_sel_err = ({1'b0, s1_sel} >= NUM_REGS_X);
        rd_sel_err = ({1'b0, rd_sel} >= NUM_REGS_X);
        s1_operand = s1_sel_err ? '0 : regs[s1_sel];
        rd_data    = rd_sel_err ? '0 : regs[rd_sel];
    end

    reg_update_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op      (s1_op),
        .operand (s1_operand),
        .data    (s1_data),
        .sel_err (s1_sel_err),
        .result  (alu_result),
        .carry   (alu_carry),
        .err     (alu_err),
        .we      (alu_we)
    );

    always_comb begin
        wr_dec = '0;
        if (alu_we) begin
            wr_dec = NUM_REGS'(1) << s1_sel;
        end
    end

    // Register array
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (advance && alu_we) begin
            regs[s1_sel] <= alu_result;
        end
    end

    // S1 stage
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_NOP;
            s1_sel   <= '0;
            s1_data  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= cmd_op;
            s1_sel   <= cmd_sel;
            s1_data  <= cmd_data;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Done register and write strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            done_valid <= 1'b0;
            done_sel   <= '0;
            done_value <= '0;
            done_zero  <= 1'b0;
            done_carry <= 1'b0;
            done_err   <= 1'b0;
            wr_onehot  <= '0;
        end else begin
            wr_onehot <= '0;
            if (advance) begin
                done_valid <= 1'b1;
                done_sel   <= s1_sel;
                done_value <= alu_result;
                done_zero  <= (alu_result == '0);
                done_carry <= alu_carry;
                done_err   <= alu_err;
                wr_onehot  <= wr_dec;
            end else if (done_ready) begin
                done_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_update_unit.sv
module tb_reg_update_unit;
    import reg_update_pkg::*;

    localparam int NUM_REGS = 8;
    localparam int DATA_W   = 16;
    localparam int SEL_W    = 3;

    logic                clk;
    logic                reset;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [2:0]          cmd_op;
    logic [SEL_W-1:0]    cmd_sel;
    logic [DATA_W-1:0]   cmd_data;
    logic [SEL_W-1:0]    rd_sel;
    logic [DATA_W-1:0]   rd_data;
    logic [NUM_REGS-1:0] wr_onehot;
    logic                done_valid;
    logic                done_ready;
    logic [SEL_W-1:0]    done_sel;
    logic [DATA_W-1:0]   done_value;
    logic                done_zero;
    logic                done_carry;
    logic                done_err;

    reg_update_unit #(
        .NUM_REGS  (NUM_REGS),
        .DATA_W    (DATA_W),
        .SEL_W     (SEL_W),
        .RESET_VAL (16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_sel    (cmd_sel),
        .cmd_data   (cmd_data),
        .rd_sel     (rd_sel),
        .rd_data    (rd_data),
        .wr_onehot  (wr_onehot),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_sel   (done_sel),
        .done_value (done_value),
        .done_zero  (done_zero),
        .done_carry (done_carry),
        .done_err   (done_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] value;
        logic        zero;
        logic        carry;
        logic        err;
        logic [7:0]  onehot;
        bit          chk_lat;
        int          pcyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation when a fresh result appears, then checks that
    // a stalled result stays put and that wr_onehot never repeats.
    bit          mon_en    = 1'b0;
    bit          prev_free = 1'b1;
    exp_t        me;
    logic [21:0] held;

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (done_valid && prev_free) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got sel %0d value %0h expected none",
                             done_sel, done_value);
                end else begin
                    me = sb.pop_front();
                    chk("done_sel",   done_sel,   me.sel);
                    chk("done_value", done_value, me.value);
                    chk("done_zero",  done_zero,  me.zero);
                    chk("done_carry", done_carry, me.carry);
                    chk("done_err",   done_err,   me.err);
                    chk("wr_onehot",  wr_onehot,  me.onehot);
                    if (me.chk_lat) chk("done_latency", cyc - me.pcyc, 2);
                end
                held = {done_sel, done_value, done_zero, done_carry, done_err};
            end else if (done_valid) begin
                chk("done_hold_stable",
                    {done_sel, done_value, done_zero, done_carry, done_err}, held);
                chk("no_dup_write", wr_onehot, 0);
            end else begin
                chk("idle_no_write", wr_onehot, 0);
            end
            prev_free = !done_valid || done_ready;
        end else begin
            prev_free = 1'b1;
        end
    end

    // Drive one command; push its expected result once it is accepted.
    task automatic issue(input logic [2:0] op, input int sel, input logic [15:0] data,
                         input logic [15:0] ev, input logic ez, input logic ec,
                         input logic ee, input logic [7:0] eoh,
                         input bit push, input bit lat, input bit want_ready);
        exp_t e;
        int   n;
        n         = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel[2:0];
        cmd_data  = data;
        @(negedge clk);
        if (want_ready) chk("cmd_ready_now", cmd_ready, 1);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got cmd_ready 0 expected 1 within 50 cycles");
            cmd_valid = 1'b0;
            return;
        end
        e.sel     = sel[2:0];
        e.value   = ev;
        e.zero    = ez;
        e.carry   = ec;
        e.err     = ee;
        e.onehot  = eoh;
        e.chk_lat = lat;
        e.pcyc    = cyc;
        @(posedge clk);
        if (push) sb.push_back(e);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_rd(input string name, input int sel, input logic [15:0] exp);
        rd_sel = sel[2:0];
        #1;
        chk(name, rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 3'b000;
        cmd_sel    = '0;
        cmd_data   = '0;
        rd_sel     = '0;
        done_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_cmd_ready",  cmd_ready,  1);
        chk("rst_wr_onehot",  wr_onehot,  0);
        chk("rst_done_fields", {done_sel, done_value, done_zero, done_carry, done_err}, 0);
        for (int i = 0; i < NUM_REGS; i++) check_rd($sformatf("rst_rd_%0d", i), i, 16'h0000);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // INC PC
        issue(OP_INC, IDX_PC, 16'h0, 16'h0001, 0, 0, 0, 8'h10, 1, 1, 1);
        repeat (3) @(posedge clk);
        #1;

        // LOAD AC, INC AC, INCSZ AC back-to-back
        issue(OP_LOAD,  IDX_AC, 16'hFFFE, 16'hFFFE, 0, 0, 0, 8'h01, 1, 1, 1);
        issue(OP_INC,   IDX_AC, 16'h0,    16'hFFFF, 0, 0, 0, 8'h01, 1, 1, 1);
        issue(OP_INCSZ, IDX_AC, 16'h0,    16'h0000, 1, 1, 0, 8'h01, 1, 1, 1);

        // DEC TR from 0, then ADD 2
        issue(OP_DEC, IDX_TR, 16'h0,    16'hFFFF, 0, 1, 0, 8'h40, 1, 1, 1);
        issue(OP_ADD, IDX_TR, 16'h0002, 16'h0001, 0, 1, 0, 8'h40, 1, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        check_rd("rd_ac_after_incsz", IDX_AC, 16'h0000);
        check_rd("rd_tr_after_add",   IDX_TR, 16'h0001);

        // Stall with three commands offered
        done_ready = 1'b0;
        issue(OP_LOAD, IDX_DR, 16'h1234, 16'h1234, 0, 0, 0, 8'h04, 1, 1, 1);
        issue(OP_INC,  IDX_AR, 16'h0,    16'h0001, 0, 0, 0, 8'h02, 1, 0, 1);
        rd_sel = IDX_AR[2:0];
        fork
            issue(OP_INC, IDX_IR, 16'h0, 16'h0001, 0, 0, 0, 8'h08, 1, 0, 0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_cmd_ready", cmd_ready, 0);
                    chk("stall_ar_unchanged", rd_data, 16'h0000);
                end
                @(posedge clk);
                #1;
                done_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check_rd("rd_ar_after_drain", IDX_AR, 16'h0001);
        check_rd("rd_ir_after_drain", IDX_IR, 16'h0001);
        check_rd("rd_dr_after_load",  IDX_DR, 16'h1234);

        // Reserved opcode on DR
        issue(OP_RSVD, IDX_DR, 16'h5555, 16'h1234, 0, 0, 1, 8'h00, 1, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        check_rd("rd_dr_after_rsvd", IDX_DR, 16'h1234);

        // Reset while a command sits in S1 and done is stalled
        done_ready = 1'b0;
        issue(OP_INC, IDX_PC, 16'h0, 16'h0002, 0, 0, 0, 8'h10, 1, 1, 1);
        issue(OP_INC, IDX_AC, 16'h0, 16'h0001, 0, 0, 0, 8'h01, 0, 0, 1);
        @(negedge clk);
        chk("pre_rst_cmd_ready", cmd_ready, 0);
        check_rd("pre_rst_ac_unchanged", IDX_AC, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        done_ready = 1'b1;
        @(negedge clk);
        chk("midrst_done_valid", done_valid, 0);
        chk("midrst_cmd_ready",  cmd_ready,  1);
        for (int i = 0; i < NUM_REGS; i++) check_rd($sformatf("midrst_rd_%0d", i), i, 16'h0000);
        repeat (3) @(posedge clk);
        #1;

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
